// File: rtl/regfile_dump_engine.sv
// Debug dump engine: sweeps the register file two registers per read cycle
// and streams each word, then an XOR checksum, over a valid/ready interface.
module regfile_dump_engine #(
   parameter int NUM_REGS = 32
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic        core_halted,
   output logic [4:0]  Rs1,
   output logic [4:0]  Rs2,
   input  logic [31:0] read_data1,
   input  logic [31:0] read_data2,
   output logic [31:0] out_data,
   output logic [4:0]  out_idx,
   output logic        out_last,
   output logic        out_valid,
   input  logic        out_ready,
   output logic        busy,
   output logic        done
);

   localparam int KW = $clog2(NUM_REGS / 2) + 1;
   localparam logic [KW-1:0] K_LAST = KW'(NUM_REGS / 2 - 1);

   localparam logic [2:0] S_IDLE     = 3'd0;
   localparam logic [2:0] S_READ     = 3'd1;
   localparam logic [2:0] S_SEND_A   = 3'd2;
   localparam logic [2:0] S_SEND_B   = 3'd3;
   localparam logic [2:0] S_SEND_SUM = 3'd4;
   localparam logic [2:0] S_DONE     = 3'd5;

   logic [2:0]    state_q, state_d;
   logic [KW-1:0] k_q, k_d;
   logic [31:0]   sum_q, sum_d;
   logic [31:0]   buf_a_q, buf_a_d;
   logic [31:0]   buf_b_q, buf_b_d;

   logic [4:0]    rs1_q, rs1_d;
   logic [4:0]    rs2_q, rs2_d;
   logic [31:0]   out_data_q, out_data_d;
   logic [4:0]    out_idx_q, out_idx_d;
   logic          out_last_q, out_last_d;
   logic          out_valid_q, out_valid_d;
   logic          busy_q, busy_d;
   logic          done_q, done_d;
   logic [4:0]    base_s;

   always_comb begin
      state_d = state_q;
      k_d     = k_q;
      sum_d   = sum_q;
      buf_a_d = buf_a_q;
      buf_b_d = buf_b_q;
      case (state_q)
         S_IDLE: begin
            if (start && core_halted) begin
               state_d = S_READ;
               k_d     = '0;
               sum_d   = 32'h0;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_READ: begin
            buf_a_d = read_data1;
            buf_b_d = read_data2;
            sum_d   = sum_q ^ read_data1 ^ read_data2;
            state_d = S_SEND_A;
         end
         S_SEND_A: begin
            if (out_ready) begin
               state_d = S_SEND_B;
            end else begin
               state_d = S_SEND_A;
            end
         end
         S_SEND_B: begin
            if (out_ready) begin
               if (k_q == K_LAST) begin
                  state_d = S_SEND_SUM;
               end else begin
                  k_d     = k_q + KW'(1);
                  state_d = S_READ;
               end
            end else begin
               state_d = S_SEND_B;
            end
         end
         S_SEND_SUM: begin
            if (out_ready) begin
               state_d = S_DONE;
            end else begin
               state_d = S_SEND_SUM;
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Outputs are decoded from the next state so every port comes straight from a flop.
   always_comb begin
      base_s      = 5'({k_d, 1'b0});
      rs1_d       = 5'd0;
      rs2_d       = 5'd0;
      out_data_d  = 32'h0;
      out_idx_d   = 5'd0;
      out_last_d  = 1'b0;
      out_valid_d = 1'b0;
      busy_d      = (state_d != S_IDLE);
      done_d      = 1'b0;
      case (state_d)
         S_READ: begin
            rs1_d = base_s;
            rs2_d = base_s | 5'd1;
         end
         S_SEND_A: begin
            rs1_d       = base_s;
            rs2_d       = base_s | 5'd1;
            out_data_d  = buf_a_d;
            out_idx_d   = base_s;
            out_valid_d = 1'b1;
         end
         S_SEND_B: begin
            rs1_d       = base_s;
            rs2_d       = base_s | 5'd1;
            out_data_d  = buf_b_d;
            out_idx_d   = base_s | 5'd1;
            out_valid_d = 1'b1;
         end
         S_SEND_SUM: begin
            out_data_d  = sum_d;
            out_last_d  = 1'b1;
            out_valid_d = 1'b1;
         end
         S_DONE:  done_d = 1'b1;
         default: done_d = 1'b0;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_IDLE;
         k_q         <= '0;
         sum_q       <= 32'h0;
         buf_a_q     <= 32'h0;
         buf_b_q     <= 32'h0;
         rs1_q       <= 5'd0;
         rs2_q       <= 5'd0;
         out_data_q  <= 32'h0;
         out_idx_q   <= 5'd0;
         out_last_q  <= 1'b0;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         k_q         <= k_d;
         sum_q       <= sum_d;
         buf_a_q     <= buf_a_d;
         buf_b_q     <= buf_b_d;
         rs1_q       <= rs1_d;
         rs2_q       <= rs2_d;
         out_data_q  <= out_data_d;
         out_idx_q   <= out_idx_d;
         out_last_q  <= out_last_d;
         out_valid_q <= out_valid_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
      end
   end

   assign Rs1       = rs1_q;
   assign Rs2       = rs2_q;
   assign out_data  = out_data_q;
   assign out_idx   = out_idx_q;
   assign out_last  = out_last_q;
   assign out_valid = out_valid_q;
   assign busy      = busy_q;
   assign done      = done_q;

endmodule

// File: tb/tb_regfile_dump_engine.sv
// Directed bench for regfile_dump_engine: table of full dumps plus hand-written
// sequences for halt gating, mid-dump reset and a NUM_REGS=4 build.
module tb_regfile_dump_engine;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        start = 1'b0;
   logic        core_halted = 1'b0;
   logic        out_ready = 1'b0;
   logic [4:0]  Rs1, Rs2;
   logic [31:0] read_data1, read_data2;
   logic [31:0] out_data;
   logic [4:0]  out_idx;
   logic        out_last, out_valid, busy, done;

   logic        start4 = 1'b0;
   logic        ready4 = 1'b0;
   logic [4:0]  r4_rs1, r4_rs2;
   logic [31:0] r4_rd1, r4_rd2, r4_data;
   logic [4:0]  r4_idx;
   logic        r4_last, r4_valid, r4_busy, r4_done;

   logic [31:0] regs [32];

   int vec_cnt = 0;
   int err_cnt = 0;

   always #5 clk = ~clk;

   assign read_data1 = regs[Rs1];
   assign read_data2 = regs[Rs2];
   assign r4_rd1     = regs[r4_rs1];
   assign r4_rd2     = regs[r4_rs2];

   regfile_dump_engine #(.NUM_REGS(32)) dut (
      .clk(clk), .rst(rst), .start(start), .core_halted(core_halted),
      .Rs1(Rs1), .Rs2(Rs2), .read_data1(read_data1), .read_data2(read_data2),
      .out_data(out_data), .out_idx(out_idx), .out_last(out_last),
      .out_valid(out_valid), .out_ready(out_ready), .busy(busy), .done(done)
   );

   regfile_dump_engine #(.NUM_REGS(4)) dut4 (
      .clk(clk), .rst(rst), .start(start4), .core_halted(core_halted),
      .Rs1(r4_rs1), .Rs2(r4_rs2), .read_data1(r4_rd1), .read_data2(r4_rd2),
      .out_data(r4_data), .out_idx(r4_idx), .out_last(r4_last),
      .out_valid(r4_valid), .out_ready(ready4), .busy(r4_busy), .done(r4_done)
   );

   typedef struct {
      logic [31:0] x0;
      logic [31:0] x1;
      logic [31:0] x31;
      int          mode;     // 0: ready high, 1: ready toggling, 2: start pulsed while busy
      logic [31:0] exp_sum;
   } vec_t;

   vec_t vecs [5];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      vec_cnt++;
      if (act !== exp) begin
         err_cnt++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic load_regs(input logic [31:0] x0, input logic [31:0] x1, input logic [31:0] x31);
      for (int r = 0; r < 32; r++) regs[r] = 32'h0;
      regs[5]  = 32'd5;
      regs[10] = 32'd10;
      regs[0]  = x0;
      regs[1]  = x1;
      regs[31] = x31;
   endtask

   // Runs one 32-register dump from a start pulse and checks every word and the timing.
   task automatic run_dump(input int mode, input logic [31:0] exp_sum);
      int          exp_idx, stalls, done_at, done_cnt, idle_at, words;
      logic        pend, fin;
      logic [37:0] prev;
      exp_idx = 0; stalls = 0; done_at = -1; done_cnt = 0; idle_at = -1; words = 0;
      pend = 1'b0; fin = 1'b0; prev = '0;
      @(negedge clk);
      core_halted = 1'b1;
      start       = 1'b1;
      out_ready   = 1'b1;
      @(posedge clk);
      for (int i = 0; i < 300 && !fin; i++) begin
         @(negedge clk);
         start = (mode == 2 && (i == 10 || i == 49)) ? 1'b1 : 1'b0;
         if (pend) chk("hold_stable", {out_valid, out_last, out_idx, out_data}, {1'b1, prev});
         out_ready = (mode == 1) ? ((i % 2) == 0) : 1'b1;
         if (done) begin
            done_at = i;
            done_cnt++;
         end
         if (out_valid && !out_ready) stalls++;
         pend = out_valid && !out_ready;
         prev = {out_last, out_idx, out_data};
         if (out_valid && out_ready) begin
            if (!out_last) begin
               chk("word_idx", out_idx, exp_idx);
               chk("word_data", out_data, regs[exp_idx]);
               exp_idx++;
            end else begin
               chk("sum_after_32", exp_idx, 32);
               chk("sum_idx", out_idx, 0);
               chk("checksum", out_data, exp_sum);
            end
            words++;
         end
         if (i > 0 && !busy) begin
            fin     = 1'b1;
            idle_at = i;
         end
      end
      chk("dump_finished", fin, 1);
      chk("done_cycle", done_at, 49 + stalls);
      chk("done_pulses", done_cnt, 1);
      chk("idle_cycle", idle_at, 50 + stalls);
      chk("word_total", words, 33);
      @(negedge clk);
      chk("stay_idle", busy, 0);
   endtask

   initial begin
      logic found, fin4;
      int   exp4, done4, words4;

      vecs[0] = '{x0: 32'h0,        x1: 32'h0,        x31: 32'h0,        mode: 0, exp_sum: 32'h0000000F};
      vecs[1] = '{x0: 32'h0,        x1: 32'hDEADBEEF, x31: 32'h12345678, mode: 0, exp_sum: 32'hCC99E898};
      vecs[2] = '{x0: 32'h0,        x1: 32'hDEADBEEF, x31: 32'h12345678, mode: 1, exp_sum: 32'hCC99E898};
      vecs[3] = '{x0: 32'h0,        x1: 32'h0,        x31: 32'h0,        mode: 2, exp_sum: 32'h0000000F};
      vecs[4] = '{x0: 32'hA5A5A5A5, x1: 32'h0,        x31: 32'h0,        mode: 0, exp_sum: 32'hA5A5A5AA};

      load_regs(32'h0, 32'h0, 32'h0);
      #1 rst = 1'b1;
      #2;
      chk("rst_valid", out_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_rs", {Rs1, Rs2}, 0);
      chk("rst_data", {out_last, out_idx, out_data}, 0);
      repeat (2) @(negedge clk);
      rst = 1'b0;

      // start without core_halted is ignored
      @(negedge clk);
      core_halted = 1'b0;
      start       = 1'b1;
      repeat (3) begin
         @(negedge clk);
         chk("nohalt_busy", busy, 0);
         chk("nohalt_valid", out_valid, 0);
      end
      start = 1'b0;

      foreach (vecs[v]) begin
         load_regs(vecs[v].x0, vecs[v].x1, vecs[v].x31);
         run_dump(vecs[v].mode, vecs[v].exp_sum);
      end

      // reset while SEND_B of pair 7 is waiting for ready
      load_regs(32'h0, 32'h0, 32'h0);
      @(negedge clk);
      core_halted = 1'b1;
      start       = 1'b1;
      out_ready   = 1'b1;
      @(posedge clk);
      found = 1'b0;
      for (int i = 0; i < 100 && !found; i++) begin
         @(negedge clk);
         start = 1'b0;
         if (out_valid && out_idx == 5'd15) begin
            out_ready = 1'b0;
            found     = 1'b1;
         end
      end
      chk("reach_pair7_b", found, 1);
      chk("pair7_rs1", Rs1, 14);
      #2 rst = 1'b1;
      #1;
      chk("midrst_valid", out_valid, 0);
      chk("midrst_busy", busy, 0);
      chk("midrst_rs", {Rs1, Rs2}, 0);
      chk("midrst_done", done, 0);
      @(negedge clk);
      rst       = 1'b0;
      out_ready = 1'b1;
      run_dump(0, 32'h0000000F);

      // NUM_REGS=4 build
      for (int r = 0; r < 32; r++) regs[r] = 32'h0;
      regs[0] = 32'h11111111;
      regs[1] = 32'h22222222;
      regs[2] = 32'h44444444;
      regs[3] = 32'h88888888;
      @(negedge clk);
      start4 = 1'b1;
      ready4 = 1'b1;
      @(posedge clk);
      exp4 = 0; done4 = -1; words4 = 0; fin4 = 1'b0;
      for (int i = 0; i < 40 && !fin4; i++) begin
         @(negedge clk);
         start4 = 1'b0;
         if (r4_done) done4 = i;
         if (r4_valid) begin
            if (!r4_last) begin
               chk("n4_idx", r4_idx, exp4);
               chk("n4_data", r4_data, regs[exp4]);
               exp4++;
            end else begin
               chk("n4_sum_after_4", exp4, 4);
               chk("n4_checksum", r4_data, 32'hFFFFFFFF);
            end
            words4++;
         end
         if (i > 0 && !r4_busy) fin4 = 1'b1;
      end
      chk("n4_finished", fin4, 1);
      chk("n4_done_cycle", done4, 7);
      chk("n4_words", words4, 5);

      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

endmodule
